ysyx_201979054_axi4_slave: RTL and testbench
============================================

YSYX_201979054_AXI4_SLAVE -- requirements
Module: ysyx_201979054_axi4_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning byte address of memory word 0.
REQ-002 SHALL have parameter MEM_DEPTH, default 512, meaning number of 64-bit words held (4 KiB).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port arst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have AW channel ports: i_awvalid in 1, o_awready out 1, i_awid in 4, i_awaddr in 32, i_awlen in 8, i_awsize in 3, i_awburst in 2.
REQ-006 SHALL have W channel ports: i_wvalid in 1, o_wready out 1, i_wdata in 64, i_wstrb in 8, i_wlast in 1.
REQ-007 SHALL have B channel ports: o_bvalid out 1, i_bready in 1, o_bid out 4, o_bresp out 2.
REQ-008 SHALL have AR channel ports: i_arvalid in 1, o_arready out 1, i_arid in 4, i_araddr in 32, i_arlen in 8, i_arsize in 3, i_arburst in 2.
REQ-009 SHALL have R channel ports: o_rvalid out 1, i_rready in 1, o_rid out 4, o_rdata out 64, o_rresp out 2, o_rlast out 1.

Function
REQ-010 SHALL be the AXI4 responder for the core's AXI4 master: one outstanding transaction total; FSM states IDLE, W_DATA, W_RESP, R_DATA.
REQ-011 IDLE: o_awready=1 and o_arready=1; all other valids/readies 0.
REQ-012 IDLE with i_awvalid and i_arvalid both high in the same cycle: SHALL accept AW only (write priority); o_arready SHALL drop that cycle; AR accepted after return to IDLE.
REQ-013 AW handshake: latch id, addr, len, size, burst; beat counter=0; go to W_DATA next cycle.
REQ-014 W_DATA: o_wready=1; each W handshake writes bytes of i_wdata where i_wstrb[k]=1 into word at current address; counter increments.
REQ-015 Address advance per beat: burst 2'b00 (FIXED) holds address; any other value adds (1 << size) bytes, 32-bit wrap-around.
REQ-016 Word index = (addr - BASE_ADDR) >> 3; beat in range iff (addr - BASE_ADDR) < MEM_DEPTH*8, unsigned.
REQ-017 Out-of-range beat: write dropped, read data 64'h0, transaction response latched as DECERR (2'b11).
REQ-018 W_DATA leaves on handshake with i_wlast=1 to W_RESP; if i_wlast disagrees with counter==len at any beat, response latched SLVERR (2'b10) unless already DECERR; data still written for in-range beats.
REQ-019 W_RESP: o_bvalid=1, o_bid=latched id, o_bresp=OKAY/SLVERR/DECERR; hold stable until i_bready; then IDLE next cycle.
REQ-020 AR handshake: latch id, addr, len, size, burst; go to R_DATA; first o_rvalid exactly one cycle after AR handshake (registered read).
REQ-021 R_DATA: o_rdata, o_rresp (per-beat OKAY or DECERR), o_rid, o_rlast stable while o_rvalid & !i_rready.
REQ-022 On R handshake, next beat valid the following cycle (no bubble); o_rlast=1 exactly on beat len; after last handshake, IDLE next cycle.
REQ-023 Memory write and read of same word SHALL not occur together (single outstanding); no read-during-write bypass required.

Reset
REQ-024 arst high at clock edge: state IDLE, o_bvalid=0, o_rvalid=0, o_rlast=0, o_bresp=0, o_rresp=0, o_bid=0, o_rid=0, o_rdata=0, counters and latched response cleared, from any state including mid-burst.
REQ-025 Memory contents SHALL NOT be reset; after reset mid-write, words already written keep new data.

Structure
REQ-026 Package ysyx_201979054_axi_pkg SHALL hold: burst encodings, resp encodings (OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11), FSM state enum.
REQ-027 Storage SHALL be sub-module ysyx_201979054_mem_sync: MEM_DEPTH x 64, byte-strobe write, registered read, one port.

Verification
REQ-028 Write len=3 size=3 INCR to 32'h8000_0010, data 0x11..,0x22..,0x33..,0x44.., wstrb FF, wlast on beat 3 -> BRESP OKAY, bid echoed; read back len=3 returns same four words, rlast on 4th beat only.
REQ-029 Single write to 32'h8000_0000, data 64'hAABBCCDD_11223344, wstrb 8'h0F over prior 0 -> read returns 64'h00000000_11223344.
REQ-030 AWVALID and ARVALID same cycle after reset -> awready=1, arready=0; write completes, then AR accepted; read data reflects the write.
REQ-031 Read 32'h0000_1000 len=1 -> two beats, rdata 0, rresp DECERR each; write 32'h8000_1000 (just past 4 KiB) -> BRESP DECERR, memory unchanged.
REQ-032 Write len=3 with wlast on beat 1 -> BRESP SLVERR; rready held low 5 cycles during read burst -> rdata/rlast stable throughout.
REQ-033 arst asserted during beat 2 of 8-beat read -> rvalid 0 next cycle, state IDLE, arready 1; new read succeeds with correct data.

Source files
------------

// File: rtl/ysyx_201979054_axi_pkg.sv
// ============================================================================
// Module   : ysyx_201979054_axi_pkg
// Brief    : Shared AXI4 encodings, FSM states and command record for the slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_201979054_axi_pkg;

  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_W_DATA = 2'd1;
  localparam state_t ST_W_RESP = 2'd2;
  localparam state_t ST_R_DATA = 2'd3;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_cmd_t;

  // FIXED bursts revisit one address; every other burst type steps by the beat size.
  function automatic logic [31:0] beat_advance(input logic [31:0] addr,
                                               input logic [2:0]  size,
                                               input logic [1:0]  burst);
    if (burst == BURST_FIXED) begin
      return addr;
    end
    return addr + (32'd1 << size);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_201979054_mem_sync.sv
// ============================================================================
// Module   : ysyx_201979054_mem_sync
// Brief    : Single-port DEPTH x 64 storage with byte-strobe write, registered read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_201979054_mem_sync
  import ysyx_201979054_axi_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read register only moves on a read access, so it holds through stalls.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_201979054_axi4_slave.sv
// ============================================================================
// Module   : ysyx_201979054_axi4_slave
// Brief    : Single-outstanding AXI4 memory responder backed by a 64-bit sync RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_201979054_axi4_slave
  import ysyx_201979054_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MEM_DEPTH = 512
) (
  input  logic        clk,
  input  logic        arst,
  // AW
  input  logic        i_awvalid,
  output logic        o_awready,
  input  logic [3:0]  i_awid,
  input  logic [31:0] i_awaddr,
  input  logic [7:0]  i_awlen,
  input  logic [2:0]  i_awsize,
  input  logic [1:0]  i_awburst,
  // W
  input  logic        i_wvalid,
  output logic        o_wready,
  input  logic [63:0] i_wdata,
  input  logic [7:0]  i_wstrb,
  input  logic        i_wlast,
  // B
  output logic        o_bvalid,
  input  logic        i_bready,
  output logic [3:0]  o_bid,
  output logic [1:0]  o_bresp,
  // AR
  input  logic        i_arvalid,
  output logic        o_arready,
  input  logic [3:0]  i_arid,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic [1:0]  i_arburst,
  // R
  output logic        o_rvalid,
  input  logic        i_rready,
  output logic [3:0]  o_rid,
  output logic [63:0] o_rdata,
  output logic [1:0]  o_rresp,
  output logic        o_rlast
);

  localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) * 33'd8;

  state_t      state_q, state_d;
  ax_cmd_t     cmd_q, cmd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;

  logic [31:0] nxt_addr;
  logic        cur_in;
  logic        last_beat;

  logic              mem_en;
  logic              mem_we;
  logic [31:0]       mem_byte_addr;
  logic [AW-1:0]     mem_idx;
  logic [DATA_W-1:0] mem_rdata;

  function automatic logic in_range(input logic [31:0] a);
    return {1'b0, a - BASE_ADDR} < MEM_BYTES;
  endfunction

  assign nxt_addr  = beat_advance(cmd_q.addr, cmd_q.size, cmd_q.burst);
  assign cur_in    = in_range(cmd_q.addr);
  assign last_beat = (cnt_q == cmd_q.len);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    bresp_d = bresp_q;
    rresp_d = rresp_q;
    case (state_q)
      ST_IDLE: begin
        // Writes win when both address channels present together.
        if (i_awvalid) begin
          cmd_d   = '{id: i_awid, addr: i_awaddr, len: i_awlen,
                      size: i_awsize, burst: i_awburst};
          cnt_d   = '0;
          bresp_d = RESP_OKAY;
          state_d = ST_W_DATA;
        end else if (i_arvalid) begin
          cmd_d   = '{id: i_arid, addr: i_araddr, len: i_arlen,
                      size: i_arsize, burst: i_arburst};
          cnt_d   = '0;
          rresp_d = in_range(i_araddr) ? RESP_OKAY : RESP_DECERR;
          state_d = ST_R_DATA;
        end
      end
      ST_W_DATA: begin
        if (i_wvalid) begin
          cmd_d.addr = nxt_addr;
          cnt_d      = cnt_q + 8'd1;
          if (!cur_in) begin
            bresp_d = RESP_DECERR;
          end else if ((i_wlast != last_beat) && (bresp_q != RESP_DECERR)) begin
            bresp_d = RESP_SLVERR;
          end
          if (i_wlast) begin
            state_d = ST_W_RESP;
          end
        end
      end
      ST_W_RESP: begin
        if (i_bready) begin
          state_d = ST_IDLE;
        end
      end
      ST_R_DATA: begin
        if (i_rready) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else begin
            cmd_d.addr = nxt_addr;
            cnt_d      = cnt_q + 8'd1;
            rresp_d    = in_range(nxt_addr) ? RESP_OKAY : RESP_DECERR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The single RAM port is fetched one beat ahead so read data is ready
  // the cycle after each address or R handshake.
  always_comb begin
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_byte_addr = cmd_q.addr;
    if (state_q == ST_IDLE && !i_awvalid && i_arvalid) begin
      mem_en        = 1'b1;
      mem_byte_addr = i_araddr;
    end else if (state_q == ST_W_DATA && i_wvalid) begin
      mem_en = cur_in;
      mem_we = 1'b1;
    end else if (state_q == ST_R_DATA && i_rready && !last_beat) begin
      mem_en        = 1'b1;
      mem_byte_addr = nxt_addr;
    end
  end

  assign mem_idx = AW'((mem_byte_addr - BASE_ADDR) >> 3);

  ysyx_201979054_mem_sync #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_idx),
    .wdata_i (i_wdata),
    .wstrb_i (i_wstrb),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
    end
  end

  assign o_awready = (state_q == ST_IDLE);
  assign o_arready = (state_q == ST_IDLE) && !i_awvalid;
  assign o_wready  = (state_q == ST_W_DATA);
  assign o_bvalid  = (state_q == ST_W_RESP);
  assign o_bid     = cmd_q.id;
  assign o_bresp   = bresp_q;
  assign o_rvalid  = (state_q == ST_R_DATA);
  assign o_rid     = cmd_q.id;
  assign o_rresp   = rresp_q;
  assign o_rlast   = (state_q == ST_R_DATA) && last_beat;
  // RAM output is not reset, so it only reaches the bus for in-range beats.
  assign o_rdata   = (o_rvalid && rresp_q == RESP_OKAY) ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_201979054_axi4_slave.sv
// ============================================================================
// Module   : tb_ysyx_201979054_axi4_slave
// Brief    : Directed self-checking bench for the AXI4 memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_201979054_axi4_slave;
  import ysyx_201979054_axi_pkg::*;

  logic        clk = 1'b0;
  logic        arst;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] wd [8];
  logic [7:0]  ws [8];
  logic [63:0] rd [8];
  logic [1:0]  rr [8];
  logic        rl [8];
  logic [3:0]  rid_c;
  logic [1:0]  got_resp;
  logic [3:0]  got_bid;

  always #5 clk = ~clk;

  ysyx_201979054_axi4_slave dut (
    .clk(clk), .arst(arst),
    .i_awvalid(awvalid), .o_awready(awready), .i_awid(awid), .i_awaddr(awaddr),
    .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast),
    .o_bvalid(bvalid), .i_bready(bready), .o_bid(bid), .o_bresp(bresp),
    .i_arvalid(arvalid), .o_arready(arready), .i_arid(arid), .i_araddr(araddr),
    .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
    .o_rvalid(rvalid), .i_rready(rready), .o_rid(rid), .o_rdata(rdata),
    .o_rresp(rresp), .o_rlast(rlast)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int nbeats, input int last_idx,
                          output logic [1:0] resp, output logic [3:0] b_id);
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    #1;
    for (int k = 0; k < 20 && awready !== 1'b1; k++) tick();
    chk("awready", awready, 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_idx);
      #1;
      for (int k = 0; k < 20 && wready !== 1'b1; k++) tick();
      chk("wready", wready, 1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    for (int k = 0; k < 20 && bvalid !== 1'b1; k++) tick();
    chk("bvalid", bvalid, 1);
    resp = bresp; b_id = bid;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    #1;
    for (int k = 0; k < 20 && arready !== 1'b1; k++) tick();
    chk("arready", arready, 1);
    tick();
    arvalid = 1'b0;
    chk("rvalid_first", rvalid, 1);
    rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      chk("rvalid_beat", rvalid, 1);
      rd[i] = rdata; rr[i] = rresp; rl[i] = rlast; rid_c = rid;
      tick();
    end
    rready = 1'b0;
    chk("rvalid_done", rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    arst = 1'b1;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    repeat (3) tick();
    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    arst = 1'b0;

    // Simultaneous AW/AR: write first, read afterwards sees the written zero.
    awvalid = 1; awid = 4'h5; awaddr = 32'h8000_0000; awlen = 0; awsize = 3; awburst = BURST_INCR;
    arvalid = 1; arid = 4'h6; araddr = 32'h8000_0000; arlen = 0; arsize = 3; arburst = BURST_INCR;
    #1;
    chk("both_awready", awready, 1);
    chk("both_arready", arready, 0);
    tick();
    awvalid = 0;
    wvalid = 1; wdata = 64'h0; wstrb = 8'hFF; wlast = 1;
    #1;
    chk("both_wready", wready, 1);
    tick();
    wvalid = 0; wlast = 0;
    #1;
    chk("both_bvalid", bvalid, 1);
    chk("both_bresp", bresp, RESP_OKAY);
    chk("both_bid", bid, 4'h5);
    bready = 1;
    tick();
    bready = 0;
    #1;
    chk("both_arready_after", arready, 1);
    tick();
    arvalid = 0;
    chk("both_rvalid", rvalid, 1);
    chk("both_rdata", rdata, 64'h0);
    chk("both_rid", rid, 4'h6);
    chk("both_rlast", rlast, 1);
    rready = 1;
    tick();
    rready = 0;
    chk("both_rvalid_done", rvalid, 0);

    // Partial strobe over zero.
    wd[0] = 64'hAABBCCDD_11223344; ws[0] = 8'h0F;
    do_write(4'h1, 32'h8000_0000, 8'd0, 3'd3, BURST_INCR, 1, 0, got_resp, got_bid);
    chk("strb_bresp", got_resp, RESP_OKAY);
    chk("strb_bid", got_bid, 4'h1);
    do_read(4'h2, 32'h8000_0000, 8'd0, 3'd3, BURST_INCR);
    chk("strb_rdata", rd[0], 64'h00000000_11223344);
    chk("strb_rresp", rr[0], RESP_OKAY);

    // Four-beat INCR write and readback.
    wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
    wd[2] = 64'h3333_3333_3333_3333; wd[3] = 64'h4444_4444_4444_4444;
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    do_write(4'hA, 32'h8000_0010, 8'd3, 3'd3, BURST_INCR, 4, 3, got_resp, got_bid);
    chk("burst_bresp", got_resp, RESP_OKAY);
    chk("burst_bid", got_bid, 4'hA);
    do_read(4'h3, 32'h8000_0010, 8'd3, 3'd3, BURST_INCR);
    chk("burst_rid", rid_c, 4'h3);
    chk("burst_rd0", rd[0], 64'h1111_1111_1111_1111);
    chk("burst_rd1", rd[1], 64'h2222_2222_2222_2222);
    chk("burst_rd2", rd[2], 64'h3333_3333_3333_3333);
    chk("burst_rd3", rd[3], 64'h4444_4444_4444_4444);
    chk("burst_rl0", rl[0], 0);
    chk("burst_rl1", rl[1], 0);
    chk("burst_rl2", rl[2], 0);
    chk("burst_rl3", rl[3], 1);

    // Out-of-range read and write.
    do_read(4'h4, 32'h0000_1000, 8'd1, 3'd3, BURST_INCR);
    chk("oor_rd0", rd[0], 64'h0);
    chk("oor_rr0", rr[0], RESP_DECERR);
    chk("oor_rd1", rd[1], 64'h0);
    chk("oor_rr1", rr[1], RESP_DECERR);
    chk("oor_rl1", rl[1], 1);
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    do_write(4'h2, 32'h8000_1000, 8'd0, 3'd3, BURST_INCR, 1, 0, got_resp, got_bid);
    chk("oor_bresp", got_resp, RESP_DECERR);
    do_read(4'h2, 32'h8000_0000, 8'd0, 3'd3, BURST_INCR);
    chk("oor_mem_unchanged", rd[0], 64'h00000000_11223344);

    // Early wlast gives SLVERR but beats still land.
    wd[0] = 64'h5555_5555_5555_5555; wd[1] = 64'h6666_6666_6666_6666;
    ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(4'h7, 32'h8000_0040, 8'd3, 3'd3, BURST_INCR, 2, 1, got_resp, got_bid);
    chk("slverr_bresp", got_resp, RESP_SLVERR);
    chk("slverr_bid", got_bid, 4'h7);
    do_read(4'h7, 32'h8000_0048, 8'd0, 3'd3, BURST_INCR);
    chk("slverr_data", rd[0], 64'h6666_6666_6666_6666);

    // Stall the last beat of a read for five cycles.
    arvalid = 1; arid = 4'h8; araddr = 32'h8000_0010; arlen = 3; arsize = 3; arburst = BURST_INCR;
    #1;
    chk("stall_arready", arready, 1);
    tick();
    arvalid = 0;
    rready = 1;
    repeat (3) tick();
    rready = 0;
    repeat (5) begin
      tick();
      chk("stall_rvalid", rvalid, 1);
      chk("stall_rdata", rdata, 64'h4444_4444_4444_4444);
      chk("stall_rlast", rlast, 1);
    end
    rready = 1;
    tick();
    rready = 0;
    chk("stall_done", rvalid, 0);

    // Reset in the middle of an eight-beat read.
    for (int i = 0; i < 8; i++) begin
      wd[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
      ws[i] = 8'hFF;
    end
    do_write(4'h9, 32'h8000_0100, 8'd7, 3'd3, BURST_INCR, 8, 7, got_resp, got_bid);
    chk("long_bresp", got_resp, RESP_OKAY);
    arvalid = 1; arid = 4'h9; araddr = 32'h8000_0100; arlen = 7; arsize = 3; arburst = BURST_INCR;
    #1;
    chk("mid_arready", arready, 1);
    tick();
    arvalid = 0;
    rready = 1;
    repeat (2) tick();
    chk("mid_beat2", rdata, 64'hC0DE_0000_0000_0002);
    arst = 1; rready = 0;
    tick();
    chk("mid_rvalid", rvalid, 0);
    chk("mid_arready_idle", arready, 1);
    chk("mid_rlast", rlast, 0);
    chk("mid_rdata", rdata, 64'h0);
    chk("mid_rid", rid, 0);
    arst = 0;
    do_read(4'hB, 32'h8000_0108, 8'd1, 3'd3, BURST_INCR);
    chk("post_rd0", rd[0], 64'hC0DE_0000_0000_0001);
    chk("post_rd1", rd[1], 64'hC0DE_0000_0000_0002);
    chk("post_rid", rid_c, 4'hB);

    // FIXED burst overwrites one word; narrow INCR beats merge into one word.
    wd[0] = 64'h1; wd[1] = 64'h2; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(4'hC, 32'h8000_0200, 8'd1, 3'd3, BURST_FIXED, 2, 1, got_resp, got_bid);
    chk("fixed_bresp", got_resp, RESP_OKAY);
    do_read(4'hC, 32'h8000_0200, 8'd0, 3'd3, BURST_INCR);
    chk("fixed_data", rd[0], 64'h2);
    wd[0] = 64'h0000_0000_AAAA_AAAA; ws[0] = 8'h0F;
    wd[1] = 64'hBBBB_BBBB_0000_0000; ws[1] = 8'hF0;
    do_write(4'hD, 32'h8000_0300, 8'd1, 3'd2, BURST_INCR, 2, 1, got_resp, got_bid);
    chk("narrow_bresp", got_resp, RESP_OKAY);
    do_read(4'hD, 32'h8000_0300, 8'd0, 3'd3, BURST_INCR);
    chk("narrow_data", rd[0], 64'hBBBB_BBBB_AAAA_AAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
